// File: rtl/zap_decode_irq_sched_pkg.sv
// Shared encodings for the decode-stage exception scheduler: FSM states
// and the CPSR mask bit positions.
package zap_decode_irq_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAG_IRQ = 2'd1,
      TAG_FIQ = 2'd2
   } state_t;

   localparam int I_BIT = 7;
   localparam int F_BIT = 6;

endpackage

// File: rtl/zap_decode_irq_sched_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level input; flushed to 0
// by the synchronous reset.
module zap_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/zap_decode_irq_sched.sv
// Picks one instruction boundary to tag with FIQ, IRQ or prefetch abort and
// holds the interrupt tag until writeback redirects or the ALU squashes it.
module zap_decode_irq_sched
   import zap_decode_irq_sched_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LAT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_irq,
   input  logic             i_fiq,
   input  logic             i_abt,
   input  logic [31:0]      i_cpu_mode,
   input  logic             i_instruction_valid,
   input  logic             i_fsm_busy,
   input  logic             i_clear_from_writeback,
   input  logic             i_data_stall,
   input  logic             i_clear_from_alu,
   input  logic             i_stall_from_issue,
   output logic             o_irq,
   output logic             o_fiq,
   output logic             o_abt,
   output logic             o_pending,
   output logic [LAT_W-1:0] o_latency
);

   state_t             state_q, state_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               irq_s, fiq_s;
   logic               irq_req, fiq_req, req_any;
   logic               boundary, clear_any;
   logic               unused_mode;

   assign unused_mode = ^{i_cpu_mode[31:8], i_cpu_mode[5:0]};

   zap_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_irq),
      .o_q     (irq_s)
   );

   zap_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fiq (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_fiq),
      .o_q     (fiq_s)
   );

   assign irq_req   = irq_s & ~i_cpu_mode[I_BIT];
   assign fiq_req   = fiq_s & ~i_cpu_mode[F_BIT];
   assign req_any   = irq_req | fiq_req;
   assign boundary  = i_instruction_valid & ~i_fsm_busy & ~i_data_stall & ~i_stall_from_issue;
   assign clear_any = i_clear_from_writeback | i_clear_from_alu;

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      o_irq   = 1'b0;
      o_fiq   = 1'b0;
      o_abt   = 1'b0;
      case (state_q)
         IDLE: begin
            // A clear in the same cycle kills whatever tag would be issued.
            if (!clear_any) begin
               if (boundary && fiq_req) begin
                  o_fiq   = 1'b1;
                  state_d = TAG_FIQ;
               end else if (boundary && irq_req) begin
                  o_irq   = 1'b1;
                  state_d = TAG_IRQ;
               end else begin
                  o_abt = i_abt & i_instruction_valid;
               end
            end
            if (!req_any) begin
               lat_d = '0;
            end else if (lat_q != {LAT_W{1'b1}}) begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         TAG_IRQ, TAG_FIQ: begin
            // Data stall outranks the ALU squash; writeback outranks both.
            if (i_clear_from_writeback) begin
               state_d = IDLE;
            end else if (!i_data_stall && i_clear_from_alu) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   assign o_pending = req_any | (state_q != IDLE);
   assign o_latency = lat_q;

endmodule

// File: tb/tb_zap_decode_irq_sched.sv
// Scoreboard bench: the driver predicts each cycle's outputs from the
// scheduling rules and queues them; the monitor pops and compares.
module tb_zap_decode_irq_sched;

   localparam int SYNC_STAGES = 2;
   localparam int LAT_W       = 4;
   localparam int LAT_MAX     = (1 << LAT_W) - 1;

   logic             clk = 1'b0;
   logic             i_reset = 1'b1;
   logic             i_irq = 1'b0, i_fiq = 1'b0, i_abt = 1'b0;
   logic [31:0]      i_cpu_mode = 32'h0;
   logic             i_instruction_valid = 1'b0, i_fsm_busy = 1'b0;
   logic             i_clear_from_writeback = 1'b0, i_data_stall = 1'b0;
   logic             i_clear_from_alu = 1'b0, i_stall_from_issue = 1'b0;
   logic             o_irq, o_fiq, o_abt, o_pending;
   logic [LAT_W-1:0] o_latency;

   always #5 clk = ~clk;

   zap_decode_irq_sched #(.SYNC_STAGES(SYNC_STAGES), .LAT_W(LAT_W)) dut (
      .i_clk                  (clk),
      .i_reset                (i_reset),
      .i_irq                  (i_irq),
      .i_fiq                  (i_fiq),
      .i_abt                  (i_abt),
      .i_cpu_mode             (i_cpu_mode),
      .i_instruction_valid    (i_instruction_valid),
      .i_fsm_busy             (i_fsm_busy),
      .i_clear_from_writeback (i_clear_from_writeback),
      .i_data_stall           (i_data_stall),
      .i_clear_from_alu       (i_clear_from_alu),
      .i_stall_from_issue     (i_stall_from_issue),
      .o_irq                  (o_irq),
      .o_fiq                  (o_fiq),
      .o_abt                  (o_abt),
      .o_pending              (o_pending),
      .o_latency              (o_latency)
   );

   typedef struct {
      bit en;
      int phase;
      int cyc;
      bit irq, fiq, abt, pending;
      int lat;
   } exp_t;

   string phase_names [8] = '{"reset", "irq_tag", "priority", "masking",
                              "busy_sat", "squash", "reset_mid", "random"};

   exp_t exp_q[$];
   int   n_compared = 0;
   int   n_mismatched = 0;
   int   cyc = 0;
   int   phase = 0;

   // Stimulus values for the next cycle
   bit b_rst, b_irq, b_fiq, b_abt, b_i, b_f, b_valid, b_busy;
   bit b_wb, b_ds, b_alu, b_is;

   // Reference model: raw-input history standing in for the synchronizer,
   // whether an interrupt tag is currently held, and the latency count.
   bit m_irq_hist[$];
   bit m_fiq_hist[$];
   bit m_tagged;
   int m_lat;

   task automatic applyStimulus(input bit chk);
      exp_t e;
      bit irq_req, fiq_req, bnd, clr;
      @(posedge clk);
      #1;
      i_reset                = b_rst;
      i_irq                  = b_irq;
      i_fiq                  = b_fiq;
      i_abt                  = b_abt;
      i_cpu_mode             = 32'h0000_0010 | (32'(b_i) << 7) | (32'(b_f) << 6);
      i_instruction_valid    = b_valid;
      i_fsm_busy             = b_busy;
      i_clear_from_writeback = b_wb;
      i_data_stall           = b_ds;
      i_clear_from_alu       = b_alu;
      i_stall_from_issue     = b_is;

      irq_req = m_irq_hist[0] & ~b_i;
      fiq_req = m_fiq_hist[0] & ~b_f;
      bnd     = b_valid & ~b_busy & ~b_ds & ~b_is;
      clr     = b_wb | b_alu;

      e         = '{default: 0};
      e.en      = chk;
      e.phase   = phase;
      e.cyc     = cyc;
      e.pending = irq_req | fiq_req | m_tagged;
      e.lat     = m_lat;
      if (!m_tagged && !clr) begin
         if (bnd && fiq_req)      e.fiq = 1'b1;
         else if (bnd && irq_req) e.irq = 1'b1;
         else                     e.abt = b_abt & b_valid;
      end
      exp_q.push_back(e);

      if (b_rst) begin
         m_tagged = 1'b0;
         m_lat    = 0;
         foreach (m_irq_hist[k]) m_irq_hist[k] = 1'b0;
         foreach (m_fiq_hist[k]) m_fiq_hist[k] = 1'b0;
      end else begin
         if (!m_tagged) begin
            if (!(irq_req | fiq_req)) m_lat = 0;
            else if (m_lat < LAT_MAX) m_lat = m_lat + 1;
            if (e.fiq || e.irq) m_tagged = 1'b1;
         end else if (b_wb || (!b_ds && b_alu)) begin
            m_tagged = 1'b0;
         end
         m_irq_hist.push_back(b_irq);
         void'(m_irq_hist.pop_front());
         m_fiq_hist.push_back(b_fiq);
         void'(m_fiq_hist.pop_front());
      end
      cyc++;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b1);
   endtask

   task automatic quietInputs();
      b_rst = 0; b_irq = 0; b_fiq = 0; b_abt = 0; b_i = 0; b_f = 0;
      b_valid = 1; b_busy = 0; b_wb = 0; b_ds = 0; b_alu = 0; b_is = 0;
   endtask

   task automatic cmpField(input string name, input exp_t e, input int got, input int want);
      n_compared++;
      if (got != want) begin
         n_mismatched++;
         $display("[TB] FAIL %s.%s cycle %0d: got %0d expected %0d",
                  phase_names[e.phase], name, e.cyc, got, want);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmpField("o_irq",     e, int'(o_irq),     int'(e.irq));
      cmpField("o_fiq",     e, int'(o_fiq),     int'(e.fiq));
      cmpField("o_abt",     e, int'(o_abt),     int'(e.abt));
      cmpField("o_pending", e, int'(o_pending), int'(e.pending));
      cmpField("o_latency", e, int'(o_latency), e.lat);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.en) checkOutput(e);
         end
      end
   end

   initial begin : driver
      for (int k = 0; k < SYNC_STAGES; k++) begin
         m_irq_hist.push_back(1'b0);
         m_fiq_hist.push_back(1'b0);
      end
      m_tagged = 1'b0;
      m_lat    = 0;

      phase = 0;
      quietInputs();
      b_rst = 1;
      applyStimulus(1'b0);
      runCycles(1);
      b_rst = 0;
      runCycles(3);

      phase = 1;
      b_irq = 1;
      runCycles(6);
      b_irq = 0;
      b_wb  = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(4);
      b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(3);

      phase = 2;
      b_irq = 1; b_fiq = 1; b_abt = 1;
      runCycles(5);
      b_irq = 0; b_fiq = 0; b_abt = 0; b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(3);
      b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(2);

      phase = 3;
      b_i = 1; b_irq = 1;
      runCycles(20);
      b_i = 0;
      runCycles(3);
      b_irq = 0; b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(3);
      b_wb = 1;
      runCycles(1);
      b_wb = 0;

      phase = 4;
      b_irq = 1; b_busy = 1;
      runCycles(20);
      b_busy = 0;
      runCycles(2);
      b_irq = 0; b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(3);
      b_wb = 1;
      runCycles(1);
      b_wb = 0;

      phase = 5;
      b_fiq = 1;
      runCycles(4);
      b_alu = 1;
      runCycles(1);
      b_alu = 0;
      runCycles(3);
      b_fiq = 0;
      runCycles(3);
      b_wb = 1; b_alu = 1;
      runCycles(1);
      b_wb = 0; b_alu = 0;
      runCycles(4);

      phase = 6;
      b_irq = 1;
      runCycles(4);
      b_rst = 1;
      runCycles(1);
      b_rst = 0;
      runCycles(5);
      b_irq = 0; b_wb = 1;
      runCycles(1);
      b_wb = 0;
      runCycles(3);

      phase = 7;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) b_irq = ~b_irq;
         if ($urandom_range(0, 11) == 0) b_fiq = ~b_fiq;
         if ($urandom_range(0, 19) == 0) b_i = ~b_i;
         if ($urandom_range(0, 19) == 0) b_f = ~b_f;
         b_abt   = ($urandom_range(0, 3) == 0);
         b_valid = ($urandom_range(0, 9) < 8);
         b_busy  = ($urandom_range(0, 9) < 2);
         b_ds    = ($urandom_range(0, 19) < 3);
         b_is    = ($urandom_range(0, 19) < 3);
         b_wb    = ($urandom_range(0, 19) == 0);
         b_alu   = ($urandom_range(0, 14) == 0);
         b_rst   = ($urandom_range(0, 99) == 0);
         applyStimulus(1'b1);
      end
      quietInputs();
      runCycles(2);

      @(negedge clk);
      #1;
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
